// File: rtl/arb_pkg.sv
// Shared definitions for the bank write arbiter.
// Contents:
//   arb_state_e : arbiter FSM state (IDLE, XFER)
//   NUM_REQ     : number of requesters sharing the bank
//   IDX_W       : width of a requester index
//   BEAT_W      : width of the per-grant beat counter (holds up to 15)
//   next_idx()  : round-robin successor of a requester index, wrapping 3->0
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned BEAT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    // Index arithmetic is modulo NUM_REQ because NUM_REQ == 2**IDX_W.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/bank_write_arbiter_if.sv
// Request/grant bus between the write requesters and the bank arbiter.
// Signals:
//   req_in   : per-requester write request (level, held until done)
//   gnt_out  : one-hot grant
//   sel_out  : index of the granted requester
//   load_out : write strobe to the shared bank, one per accepted beat
//   busy_out : high while a grant is active
//   lock_in  : extend the current grant past BURST_LEN (only with ARB_LOCK_EN)
// Modports: master = requester side, slave = arbiter side.
// Configuration macro: ARB_LOCK_EN adds lock_in.
interface bank_write_arbiter_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req_in;
    logic [NUM_REQ-1:0] gnt_out;
    logic [IDX_W-1:0]   sel_out;
    logic               load_out;
    logic               busy_out;
`ifdef ARB_LOCK_EN
    logic               lock_in;

    modport master (
        output req_in,
        output lock_in,
        input  gnt_out,
        input  sel_out,
        input  load_out,
        input  busy_out
    );

    modport slave (
        input  req_in,
        input  lock_in,
        output gnt_out,
        output sel_out,
        output load_out,
        output busy_out
    );
`else
    modport master (
        output req_in,
        input  gnt_out,
        input  sel_out,
        input  load_out,
        input  busy_out
    );

    modport slave (
        input  req_in,
        output gnt_out,
        output sel_out,
        output load_out,
        output busy_out
    );
`endif

endinterface

// File: rtl/demux_1x4.sv
// 1-to-4 demultiplexer: routes y_in onto the output bit selected by sel_in,
// all other outputs low.
// Ports:
//   y_in   : data bit
//   sel_in : output select
//   y_out  : one-hot (or zero) output vector
module demux_1x4
    import arb_pkg::*;
(
    input  logic               y_in,
    input  logic [IDX_W-1:0]   sel_in,
    output logic [NUM_REQ-1:0] y_out
);

    always_comb begin
        y_out         = '0;
        y_out[sel_in] = y_in;
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin winner selection.
// Ports:
//   req   : request vector
//   ptr   : index with highest priority this round
//   valid : any request present
//   idx   : first requesting index at or after ptr, wrapping 3->0
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back to ptr so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bank_write_arbiter.sv
// Round-robin write arbiter for a single shared memory bank.
// A request seen in IDLE is granted on the next edge; the grant holds for up to
// BURST_LEN beats (a beat is any XFER cycle with the granted request high), or
// ends early when the granted request drops. One IDLE cycle separates grants.
// Ports:
//   clk_in : clock, rising edge
//   rst_in : asynchronous active-high reset
//   bus    : bank_write_arbiter_if.slave (req_in, gnt_out, sel_out, load_out,
//            busy_out, and lock_in when ARB_LOCK_EN is defined)
// Parameters:
//   BURST_LEN : maximum beats per grant, 1..15
// Configuration macro: ARB_LOCK_EN adds lock_in; lock_in high on the last beat
// restarts the burst for the same requester instead of releasing it.
module bank_write_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    bank_write_arbiter_if.slave   bus
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               req_sel;
    logic               lock;
    logic [BEAT_W-1:0]  beat_inc;
    logic               last_beat;
    logic               busy;
    logic               load;
    logic [NUM_REQ-1:0] gnt;

`ifdef ARB_LOCK_EN
    assign lock = bus.lock_in;
`else
    assign lock = 1'b0;
`endif

    assign req_sel   = bus.req_in[sel_q];
    assign beat_inc  = beat_q + BEAT_W'(1);
    assign last_beat = (beat_inc == BEAT_W'(BURST_LEN));

    rr_pick u_rr_pick (
        .req   (bus.req_in),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = XFER;
                    sel_d   = pick_idx;
                    beat_d  = '0;
                end
            end
            XFER: begin
                if (!req_sel) begin
                    // No beat this cycle: release without counting.
                    state_d = IDLE;
                    ptr_d   = next_idx(sel_q);
                    beat_d  = '0;
                end else if (last_beat) begin
                    beat_d = '0;
                    if (!lock) begin
                        state_d = IDLE;
                        ptr_d   = next_idx(sel_q);
                    end
                end else begin
                    beat_d = beat_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state_q == XFER);
        load = busy & req_sel;
    end

    demux_1x4 u_gnt_demux (
        .y_in   (busy),
        .sel_in (sel_q),
        .y_out  (gnt)
    );

    assign bus.gnt_out  = gnt;
    assign bus.sel_out  = sel_q;
    assign bus.busy_out = busy;
    assign bus.load_out = load;

endmodule

// File: tb/tb_bank_write_arbiter.sv
// Self-checking bench for bank_write_arbiter (BURST_LEN = 4).
// Each table row is one clock cycle: inputs are driven after the falling edge
// and outputs compared 1 time unit later, before the next rising edge.
// Configuration macro: ARB_LOCK_EN enables the lock_in sequence.
module tb_bank_write_arbiter;
    import arb_pkg::*;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       load;
        logic       busy;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    bank_write_arbiter_if bus ();

    bank_write_arbiter #(
        .BURST_LEN (4)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] gnt, input logic [1:0] sel,
                           input logic load, input logic busy);
        chk({name, ".gnt"}, bus.gnt_out, gnt);
        chk({name, ".sel"}, {2'b00, bus.sel_out}, {2'b00, sel});
        chk({name, ".load"}, {3'b000, bus.load_out}, {3'b000, load});
        chk({name, ".busy"}, {3'b000, bus.busy_out}, {3'b000, busy});
    endtask

    task automatic add(input logic r, input logic [3:0] req, input logic [3:0] gnt,
                       input logic [1:0] sel, input logic load, input logic busy,
                       input string name);
        vec_t v;
        v.rst = r; v.req = req; v.gnt = gnt; v.sel = sel;
        v.load = load; v.busy = busy; v.name = name;
        vecs.push_back(v);
    endtask

    // Invariants checked every cycle, away from both edges.
    always @(negedge clk) begin
        #3;
        n_cmp++;
        if (!$onehot0(bus.gnt_out)) begin
            n_bad++;
            $display("FAIL onehot0_gnt: got %b, want at most one bit", bus.gnt_out);
        end
        n_cmp++;
        if (bus.load_out && !bus.busy_out) begin
            n_bad++;
            $display("FAIL load_implies_busy: got load=1 busy=0, want busy=1");
        end
    end

    initial begin
        logic [3:0] oh;
        logic [1:0] ix;

        bus.req_in = '0;
`ifdef ARB_LOCK_EN
        bus.lock_in = 1'b0;
`endif

        // ---- vector table ----
        add(1, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset0");
        add(1, 4'b0100, 4'b0000, 2'd0, 0, 0, "reset1");
        // Single requester 2: grant one cycle later, four beats, then IDLE.
        add(0, 4'b0100, 4'b0000, 2'd0, 0, 0, "r026_idle");
        for (int b = 0; b < 4; b++) add(0, 4'b0100, 4'b0100, 2'd2, 1, 1, "r026_beat");
        add(0, 4'b0000, 4'b0000, 2'd2, 0, 0, "r026_done");
        // ptr now 3: with everyone requesting, 3 must win.
        add(0, 4'b1111, 4'b0000, 2'd2, 0, 0, "ptr3_idle");
        add(0, 4'b1111, 4'b1000, 2'd3, 1, 1, "ptr3_gnt");
        add(0, 4'b0000, 4'b1000, 2'd3, 0, 1, "ptr3_drop");
        add(0, 4'b0000, 4'b0000, 2'd3, 0, 0, "ptr3_end");
        add(1, 4'b0000, 4'b0000, 2'd0, 0, 0, "reset2");
        // All requesting from ptr 0: order 0,1,2,3,0, one IDLE between grants.
        add(0, 4'b1111, 4'b0000, 2'd0, 0, 0, "rr_idle");
        for (int g = 0; g < 5; g++) begin
            ix = 2'(g % 4);
            oh = 4'b0001 << ix;
            for (int b = 0; b < 4; b++) add(0, 4'b1111, oh, ix, 1, 1, "rr_beat");
            add(0, (g == 4) ? 4'b0000 : 4'b1111, 4'b0000, ix, 0, 0, "rr_gap");
        end
        // ptr 1: requester 1 drops after beat 2; other bits toggle meanwhile.
        add(0, 4'b0010, 4'b0000, 2'd0, 0, 0, "r028_idle");
        add(0, 4'b0010, 4'b0010, 2'd1, 1, 1, "r028_b1");
        add(0, 4'b1110, 4'b0010, 2'd1, 1, 1, "r028_b2");
        add(0, 4'b1101, 4'b0010, 2'd1, 0, 1, "r028_drop");
        add(0, 4'b0000, 4'b0000, 2'd1, 0, 0, "r028_idle2");
        // ptr advanced to 2.
        add(0, 4'b1111, 4'b0000, 2'd1, 0, 0, "r028_ptr");
        add(0, 4'b1111, 4'b0100, 2'd2, 1, 1, "r028_gnt2");
        add(0, 4'b0000, 4'b0100, 2'd2, 0, 1, "r028_rel");
        add(0, 4'b0000, 4'b0000, 2'd2, 0, 0, "r028_end");

        foreach (vecs[i]) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            bus.req_in = vecs[i].req;
            #1;
            chk_out(vecs[i].name, vecs[i].gnt, vecs[i].sel, vecs[i].load, vecs[i].busy);
        end

        // ---- asynchronous reset during beat 3 (ptr is 3 beforehand) ----
        @(negedge clk); bus.req_in = 4'b1000; #1 chk_out("r029_idle", 4'b0000, 2'd2, 0, 0);
        @(negedge clk); #1 chk_out("r029_b1", 4'b1000, 2'd3, 1, 1);
        @(negedge clk); #1 chk_out("r029_b2", 4'b1000, 2'd3, 1, 1);
        @(negedge clk); #1 chk_out("r029_b3", 4'b1000, 2'd3, 1, 1);
        #2 rst = 1'b1;
        #1 chk_out("r029_async", 4'b0000, 2'd0, 0, 0);
        @(negedge clk); rst = 1'b0; bus.req_in = 4'b1111;
        #1 chk_out("r029_idle2", 4'b0000, 2'd0, 0, 0);
        @(negedge clk); #1 chk_out("r029_from0", 4'b0001, 2'd0, 1, 1);
        @(negedge clk); bus.req_in = 4'b0000; #1 chk_out("r029_rel", 4'b0001, 2'd0, 0, 1);
        @(negedge clk); #1 chk_out("r029_end", 4'b0000, 2'd0, 0, 0);

`ifdef ARB_LOCK_EN
        // ---- lock: 8 back-to-back beats to requester 0, then requester 1 ----
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; bus.req_in = 4'b0011; bus.lock_in = 1'b1;
        #1 chk_out("r030_idle", 4'b0000, 2'd0, 0, 0);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            if (b >= 4) bus.lock_in = 1'b0;
            #1 chk_out("r030_beat", 4'b0001, 2'd0, 1, 1);
        end
        @(negedge clk); #1 chk_out("r030_gap", 4'b0000, 2'd0, 0, 0);
        @(negedge clk); #1 chk_out("r030_next", 4'b0010, 2'd1, 1, 1);
        bus.req_in = 4'b0000;
`endif

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
